// File: rtl/conv2d_stream_driver.sv
// rtl/conv2d_stream_driver.sv - Conv2d initiator: serial words in, start/finish handshake, serial result out
module conv2d_stream_driver #(
    parameter int BITWIDTH  = 32,
    parameter int IN_WORDS  = 9,
    parameter int OUT_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BITWIDTH-1:0]           in_data,
    output logic [BITWIDTH*IN_WORDS-1:0]  conv_data,
    output logic                          conv_start,
    input  logic                          conv_finish,
    input  logic [BITWIDTH*OUT_WORDS-1:0] conv_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BITWIDTH-1:0]           out_data,
    output logic                          out_last,
    output logic                          busy
);

    localparam int MAXW = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [CW-1:0] IN_LAST  = CW'(IN_WORDS - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_WORDS - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                        state;
    state_t                        next_state;
    logic [CW-1:0]                 in_cnt;
    logic [CW-1:0]                 out_cnt;
    logic [BITWIDTH*OUT_WORDS-1:0] result_q;
    logic                          finish_q;
    logic                          in_fire;
    logic                          out_fire;
    logic                          finish_rise;

    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    // Edge detect so a finish left high from an earlier run never triggers capture
    assign finish_rise = conv_finish && !finish_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_LOAD:  if (in_fire && in_cnt == IN_LAST) next_state = S_START;
            S_START: next_state = S_WAIT;
            S_WAIT:  if (finish_rise) next_state = S_DRAIN;
            S_DRAIN: if (out_fire && out_cnt == OUT_LAST) next_state = S_LOAD;
            default: next_state = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready   = (state == S_LOAD) && !rst;
        conv_start = (state == S_START);
        out_valid  = (state == S_DRAIN);
        out_last   = (state == S_DRAIN) && (out_cnt == OUT_LAST);
        busy       = (state != S_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finish_q  <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            conv_data <= '0;
            result_q  <= '0;
        end else begin
            finish_q <= conv_finish;
            if (in_fire) begin
                in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
                for (int k = 0; k < IN_WORDS; k++) begin
                    if (in_cnt == CW'(k)) begin
                        conv_data[k*BITWIDTH +: BITWIDTH] <= in_data;
                    end
                end
            end
            if (state == S_WAIT && finish_rise) begin
                result_q <= conv_result;
            end
            if (out_fire) begin
                out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < OUT_WORDS; k++) begin
            if (out_cnt == CW'(k)) begin
                out_data = result_q[k*BITWIDTH +: BITWIDTH];
            end
        end
    end

endmodule
